// File: rtl/taxi_eth_mac_rx_stats_cnt_if.sv
// Bundle of the MAC RX stat pulses and the counter read port.
// The master drives the stat inputs and read requests; the slave is the counter block.
interface taxi_eth_mac_rx_stats_cnt_if #(
  parameter int unsigned CNT_W = 32
) ();
  logic [3:0]       stat_rx_byte;
  logic [15:0]      stat_rx_pkt_len;
  logic             stat_rx_pkt_good;
  logic             stat_rx_pkt_bad;
  logic             stat_rx_pkt_ucast;
  logic             stat_rx_pkt_mcast;
  logic             stat_rx_pkt_bcast;
  logic             stat_rx_pkt_vlan;
  logic             stat_rx_pkt_fragment;
  logic             stat_rx_pkt_jabber;
  logic             stat_rx_err_oversize;
  logic             stat_rx_err_bad_fcs;
  logic             stat_rx_err_bad_block;
  logic             stat_rx_err_framing;
  logic             stat_rx_err_preamble;
  logic             snap_req;
  logic             rd_req;
  logic [4:0]       rd_addr;
  logic             rd_ack;
  logic [CNT_W-1:0] rd_data;

  modport master (
    output stat_rx_byte, stat_rx_pkt_len, stat_rx_pkt_good, stat_rx_pkt_bad,
    output stat_rx_pkt_ucast, stat_rx_pkt_mcast, stat_rx_pkt_bcast, stat_rx_pkt_vlan,
    output stat_rx_pkt_fragment, stat_rx_pkt_jabber, stat_rx_err_oversize,
    output stat_rx_err_bad_fcs, stat_rx_err_bad_block, stat_rx_err_framing,
    output stat_rx_err_preamble, snap_req, rd_req, rd_addr,
    input  rd_ack, rd_data
  );

  modport slave (
    input  stat_rx_byte, stat_rx_pkt_len, stat_rx_pkt_good, stat_rx_pkt_bad,
    input  stat_rx_pkt_ucast, stat_rx_pkt_mcast, stat_rx_pkt_bcast, stat_rx_pkt_vlan,
    input  stat_rx_pkt_fragment, stat_rx_pkt_jabber, stat_rx_err_oversize,
    input  stat_rx_err_bad_fcs, stat_rx_err_bad_block, stat_rx_err_framing,
    input  stat_rx_err_preamble, snap_req, rd_req, rd_addr,
    output rd_ack, rd_data
  );
endinterface

// File: rtl/taxi_eth_mac_rx_stats_cnt.sv
// RX statistics accumulator: 22 live counters (bytes, frame/error pulses, length histogram),
// an atomic shadow snapshot, and a one-cycle-latency read port over the shadow copy.
module taxi_eth_mac_rx_stats_cnt #(
  parameter int unsigned CNT_W       = 32,
  parameter bit          SAT_EN      = 1'b1,
  parameter bit          CLR_ON_SNAP = 1'b1
) (
  input logic clk,
  input logic rst_n,
  taxi_eth_mac_rx_stats_cnt_if.slave bus
);
  localparam int NUM_CNT = 22;

  logic             w_eof;
  logic [4:0]       w_bin;
  logic [3:0]       w_inc    [NUM_CNT];
  logic [CNT_W:0]   w_ext    [NUM_CNT];
  logic [CNT_W-1:0] w_sum    [NUM_CNT];
  logic [CNT_W-1:0] w_rd_mux;
  logic [CNT_W-1:0] r_live   [NUM_CNT];
  logic [CNT_W-1:0] r_shadow [NUM_CNT];
  logic             r_rd_ack;
  logic [CNT_W-1:0] r_rd_data;

  assign w_eof = bus.stat_rx_pkt_good | bus.stat_rx_pkt_bad;

  // Length histogram bin index for the frame ending this cycle.
  always_comb begin
    w_bin = 5'd21;
    if (bus.stat_rx_pkt_len < 16'd64)         w_bin = 5'd14;
    else if (bus.stat_rx_pkt_len == 16'd64)   w_bin = 5'd15;
    else if (bus.stat_rx_pkt_len <= 16'd127)  w_bin = 5'd16;
    else if (bus.stat_rx_pkt_len <= 16'd255)  w_bin = 5'd17;
    else if (bus.stat_rx_pkt_len <= 16'd511)  w_bin = 5'd18;
    else if (bus.stat_rx_pkt_len <= 16'd1023) w_bin = 5'd19;
    else if (bus.stat_rx_pkt_len <= 16'd1518) w_bin = 5'd20;
  end

  // Per-counter increment for this cycle; the bin counts a frame once even if good and bad.
  always_comb begin
    for (int i = 0; i < NUM_CNT; i++) w_inc[i] = 4'd0;
    w_inc[0]  = bus.stat_rx_byte;
    w_inc[1]  = {3'b0, bus.stat_rx_pkt_good};
    w_inc[2]  = {3'b0, bus.stat_rx_pkt_bad};
    w_inc[3]  = {3'b0, bus.stat_rx_pkt_ucast};
    w_inc[4]  = {3'b0, bus.stat_rx_pkt_mcast};
    w_inc[5]  = {3'b0, bus.stat_rx_pkt_bcast};
    w_inc[6]  = {3'b0, bus.stat_rx_pkt_vlan};
    w_inc[7]  = {3'b0, bus.stat_rx_pkt_fragment};
    w_inc[8]  = {3'b0, bus.stat_rx_pkt_jabber};
    w_inc[9]  = {3'b0, bus.stat_rx_err_oversize};
    w_inc[10] = {3'b0, bus.stat_rx_err_bad_fcs};
    w_inc[11] = {3'b0, bus.stat_rx_err_bad_block};
    w_inc[12] = {3'b0, bus.stat_rx_err_framing};
    w_inc[13] = {3'b0, bus.stat_rx_err_preamble};
    for (int i = 14; i < NUM_CNT; i++) begin
      if (w_eof && (w_bin == 5'(i))) w_inc[i] = 4'd1;
    end
  end

  // Saturating or wrapping add; the carry out of CNT_W marks overflow.
  always_comb begin
    for (int i = 0; i < NUM_CNT; i++) begin
      w_ext[i] = {1'b0, r_live[i]} + {{(CNT_W - 3){1'b0}}, w_inc[i]};
      w_sum[i] = (SAT_EN && w_ext[i][CNT_W]) ? {CNT_W{1'b1}} : w_ext[i][CNT_W-1:0];
    end
  end

  // Live accumulation and snapshot capture; snapshot takes the pre-increment live value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        r_live[i]   <= '0;
        r_shadow[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (bus.snap_req) begin
          r_shadow[i] <= r_live[i];
          // Clearing still keeps this cycle's event so nothing is lost across a snapshot.
          r_live[i]   <= CLR_ON_SNAP ? {{(CNT_W - 4){1'b0}}, w_inc[i]} : w_sum[i];
        end else begin
          r_live[i]   <= w_sum[i];
        end
      end
    end
  end

  // Shadow read mux; addresses beyond the map read as zero.
  always_comb begin
    w_rd_mux = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (bus.rd_addr == 5'(i)) w_rd_mux = r_shadow[i];
    end
  end

  // Read response: ack pulses one cycle after the request, data holds until the next ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ack  <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_rd_ack <= bus.rd_req;
      if (bus.rd_req) r_rd_data <= w_rd_mux;
    end
  end

  assign bus.rd_ack  = r_rd_ack;
  assign bus.rd_data = r_rd_data;
endmodule

// File: tb/tb_taxi_eth_mac_rx_stats_cnt.sv
// Scoreboard bench: reads push expected data into per-DUT queues, monitors pop on rd_ack.
// m: 32-bit, saturating, clear-on-snap. s: 16-bit saturating, clear-on-snap.
// w: 16-bit wrapping, free-running.
module tb_taxi_eth_mac_rx_stats_cnt;
  typedef struct {
    int          addr;
    logic [63:0] exp;
    int          cyc;
  } rd_exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  rd_exp_t mq[$];
  rd_exp_t sq[$];
  rd_exp_t wq[$];
  rd_exp_t m_e, s_e, w_e;
  logic [31:0] m_exp [22];

  taxi_eth_mac_rx_stats_cnt_if #(.CNT_W(32)) m_if ();
  taxi_eth_mac_rx_stats_cnt_if #(.CNT_W(16)) s_if ();
  taxi_eth_mac_rx_stats_cnt_if #(.CNT_W(16)) w_if ();

  taxi_eth_mac_rx_stats_cnt #(.CNT_W(32), .SAT_EN(1'b1), .CLR_ON_SNAP(1'b1)) u_m (
    .clk(clk), .rst_n(rst_n), .bus(m_if)
  );
  taxi_eth_mac_rx_stats_cnt #(.CNT_W(16), .SAT_EN(1'b1), .CLR_ON_SNAP(1'b1)) u_s (
    .clk(clk), .rst_n(rst_n), .bus(s_if)
  );
  taxi_eth_mac_rx_stats_cnt #(.CNT_W(16), .SAT_EN(1'b0), .CLR_ON_SNAP(1'b0)) u_w (
    .clk(clk), .rst_n(rst_n), .bus(w_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic m_clear();
    m_if.stat_rx_byte = 4'd0;          m_if.stat_rx_pkt_len = 16'd0;
    m_if.stat_rx_pkt_good = 1'b0;      m_if.stat_rx_pkt_bad = 1'b0;
    m_if.stat_rx_pkt_ucast = 1'b0;     m_if.stat_rx_pkt_mcast = 1'b0;
    m_if.stat_rx_pkt_bcast = 1'b0;     m_if.stat_rx_pkt_vlan = 1'b0;
    m_if.stat_rx_pkt_fragment = 1'b0;  m_if.stat_rx_pkt_jabber = 1'b0;
    m_if.stat_rx_err_oversize = 1'b0;  m_if.stat_rx_err_bad_fcs = 1'b0;
    m_if.stat_rx_err_bad_block = 1'b0; m_if.stat_rx_err_framing = 1'b0;
    m_if.stat_rx_err_preamble = 1'b0;  m_if.snap_req = 1'b0;
    m_if.rd_req = 1'b0;                m_if.rd_addr = 5'd0;
  endtask

  task automatic p_clear();
    s_if.stat_rx_byte = 4'd0;          s_if.stat_rx_pkt_len = 16'd0;
    s_if.stat_rx_pkt_good = 1'b0;      s_if.stat_rx_pkt_bad = 1'b0;
    s_if.stat_rx_pkt_ucast = 1'b0;     s_if.stat_rx_pkt_mcast = 1'b0;
    s_if.stat_rx_pkt_bcast = 1'b0;     s_if.stat_rx_pkt_vlan = 1'b0;
    s_if.stat_rx_pkt_fragment = 1'b0;  s_if.stat_rx_pkt_jabber = 1'b0;
    s_if.stat_rx_err_oversize = 1'b0;  s_if.stat_rx_err_bad_fcs = 1'b0;
    s_if.stat_rx_err_bad_block = 1'b0; s_if.stat_rx_err_framing = 1'b0;
    s_if.stat_rx_err_preamble = 1'b0;  s_if.snap_req = 1'b0;
    s_if.rd_req = 1'b0;                s_if.rd_addr = 5'd0;
    w_if.stat_rx_byte = 4'd0;          w_if.stat_rx_pkt_len = 16'd0;
    w_if.stat_rx_pkt_good = 1'b0;      w_if.stat_rx_pkt_bad = 1'b0;
    w_if.stat_rx_pkt_ucast = 1'b0;     w_if.stat_rx_pkt_mcast = 1'b0;
    w_if.stat_rx_pkt_bcast = 1'b0;     w_if.stat_rx_pkt_vlan = 1'b0;
    w_if.stat_rx_pkt_fragment = 1'b0;  w_if.stat_rx_pkt_jabber = 1'b0;
    w_if.stat_rx_err_oversize = 1'b0;  w_if.stat_rx_err_bad_fcs = 1'b0;
    w_if.stat_rx_err_bad_block = 1'b0; w_if.stat_rx_err_framing = 1'b0;
    w_if.stat_rx_err_preamble = 1'b0;  w_if.snap_req = 1'b0;
    w_if.rd_req = 1'b0;                w_if.rd_addr = 5'd0;
  endtask

  // Issue a read this cycle and record the response expected one cycle later.
  task automatic m_read(input int addr, input logic [63:0] exp);
    rd_exp_t e;
    m_if.rd_req = 1'b1;
    m_if.rd_addr = 5'(addr);
    e.addr = addr; e.exp = exp; e.cyc = cyc + 1;
    mq.push_back(e);
  endtask

  task automatic p_read(input int addr, input logic [63:0] es, input logic [63:0] ew);
    rd_exp_t e;
    s_if.rd_req = 1'b1; s_if.rd_addr = 5'(addr);
    w_if.rd_req = 1'b1; w_if.rd_addr = 5'(addr);
    e.addr = addr; e.cyc = cyc + 1;
    e.exp = es; sq.push_back(e);
    e.exp = ew; wq.push_back(e);
  endtask

  task automatic m_exp_clear();
    for (int i = 0; i < 22; i++) m_exp[i] = 32'd0;
  endtask

  task automatic m_read_all();
    for (int a = 0; a < 22; a++) begin
      m_clear(); m_read(a, 64'(m_exp[a])); tick();
    end
  endtask

  task automatic m_snap();
    m_clear(); m_if.snap_req = 1'b1; tick();
  endtask

  // Monitors: every rd_ack must match the oldest outstanding read, in data and in timing.
  always @(negedge clk) begin
    if (m_if.rd_ack === 1'b1) begin
      checks++;
      if (mq.size() == 0) begin
        errors++;
        $display("FAIL m_unexpected_ack data=%0h required no ack", m_if.rd_data);
      end else begin
        m_e = mq.pop_front();
        if (64'(m_if.rd_data) !== m_e.exp || cyc != m_e.cyc) begin
          errors++;
          $display("FAIL m_read addr=%0d got=%0d@cyc%0d required=%0d@cyc%0d",
                   m_e.addr, m_if.rd_data, cyc, m_e.exp, m_e.cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (s_if.rd_ack === 1'b1) begin
      checks++;
      if (sq.size() == 0) begin
        errors++;
        $display("FAIL s_unexpected_ack data=%0h required no ack", s_if.rd_data);
      end else begin
        s_e = sq.pop_front();
        if (64'(s_if.rd_data) !== s_e.exp || cyc != s_e.cyc) begin
          errors++;
          $display("FAIL s_read addr=%0d got=%0d@cyc%0d required=%0d@cyc%0d",
                   s_e.addr, s_if.rd_data, cyc, s_e.exp, s_e.cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (w_if.rd_ack === 1'b1) begin
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL w_unexpected_ack data=%0h required no ack", w_if.rd_data);
      end else begin
        w_e = wq.pop_front();
        if (64'(w_if.rd_data) !== w_e.exp || cyc != w_e.cyc) begin
          errors++;
          $display("FAIL w_read addr=%0d got=%0d@cyc%0d required=%0d@cyc%0d",
                   w_e.addr, w_if.rd_data, cyc, w_e.exp, w_e.cyc);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    m_clear(); p_clear();
    repeat (3) tick();
    rst_n = 1'b1;

    // Reset state: every address including out-of-map ones reads zero.
    m_snap();
    m_exp_clear(); m_read_all();
    m_clear(); m_read(22, 64'd0); tick();
    m_clear(); m_read(31, 64'd0); tick();

    // 250 cycles x 8 bytes with three good unicast frames of length 60, 64, 1518.
    for (int i = 0; i < 250; i++) begin
      m_clear();
      m_if.stat_rx_byte = 4'd8;
      if (i == 50 || i == 120 || i == 249) begin
        m_if.stat_rx_pkt_good = 1'b1;
        m_if.stat_rx_pkt_ucast = 1'b1;
        m_if.stat_rx_pkt_len = (i == 50) ? 16'd60 : (i == 120) ? 16'd64 : 16'd1518;
      end
      tick();
    end
    m_snap();
    m_exp_clear();
    m_exp[0] = 32'd2000; m_exp[1] = 32'd3; m_exp[3] = 32'd3;
    m_exp[14] = 32'd1; m_exp[15] = 32'd1; m_exp[20] = 32'd1;
    m_read_all();

    // Bad frame with simultaneous errors, oversize length, unclamped byte value 15.
    m_clear();
    m_if.stat_rx_byte = 4'd15; m_if.stat_rx_pkt_bad = 1'b1; m_if.stat_rx_err_bad_fcs = 1'b1;
    m_if.stat_rx_err_framing = 1'b1; m_if.stat_rx_pkt_len = 16'd1600;
    tick();
    m_snap();
    m_exp_clear();
    m_exp[0] = 32'd15; m_exp[2] = 32'd1; m_exp[10] = 32'd1; m_exp[12] = 32'd1;
    m_exp[21] = 32'd1;
    m_read_all();

    // Clear-on-snap keeps the snap-cycle event; back-to-back snaps each re-capture.
    for (int c = 0; c < 25; c++) begin
      m_clear();
      if (c <= 9 || c == 22) m_if.stat_rx_pkt_good = 1'b1;
      if (c == 5 || c == 20 || c == 22 || c == 23) m_if.snap_req = 1'b1;
      if (c == 6)  m_read(1, 64'd5);
      if (c == 21) m_read(1, 64'd5);
      if (c == 24) m_read(1, 64'd1);
      tick();
    end
    m_clear();

    // 16-bit pair: read coincident with snap returns the pre-snap shadow.
    for (int c = 0; c < 3; c++) begin
      p_clear(); s_if.stat_rx_pkt_good = 1'b1; w_if.stat_rx_pkt_good = 1'b1;
      s_if.stat_rx_pkt_len = 16'd100; w_if.stat_rx_pkt_len = 16'd100; tick();
    end
    p_clear(); s_if.snap_req = 1'b1; w_if.snap_req = 1'b1; tick();
    for (int c = 0; c < 4; c++) begin
      p_clear(); s_if.stat_rx_pkt_good = 1'b1; w_if.stat_rx_pkt_good = 1'b1;
      s_if.stat_rx_pkt_len = 16'd100; w_if.stat_rx_pkt_len = 16'd100; tick();
    end
    p_clear(); s_if.snap_req = 1'b1; w_if.snap_req = 1'b1; p_read(1, 64'd3, 64'd3); tick();
    p_clear(); p_read(1, 64'd4, 64'd7); tick();

    // 70000 good frames of length 0: saturate at 0xFFFF vs wrap modulo 65536.
    for (int i = 0; i < 70000; i++) begin
      p_clear(); s_if.stat_rx_pkt_good = 1'b1; w_if.stat_rx_pkt_good = 1'b1; tick();
    end
    p_clear(); s_if.snap_req = 1'b1; w_if.snap_req = 1'b1; tick();
    p_clear(); p_read(1, 64'hFFFF, 64'd4471); tick();
    p_clear(); p_read(14, 64'hFFFF, 64'd4464); tick();
    p_clear(); p_read(16, 64'd0, 64'd7); tick();
    p_clear(); tick();

    // Reset asserted with a read in flight: no ack, all counters cleared.
    m_clear(); m_if.stat_rx_pkt_good = 1'b1; tick();
    m_snap();
    m_clear(); m_if.rd_req = 1'b1; m_if.rd_addr = 5'd1;
    #2 rst_n = 1'b0;
    #1 m_clear();
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (m_if.rd_ack !== 1'b0) begin
        errors++;
        $display("FAIL rst_drop_ack got=%b required=0", m_if.rd_ack);
      end
    end
    rst_n = 1'b1;
    m_snap();
    m_exp_clear(); m_read_all();
    m_clear(); tick(); tick();

    // Every issued read must have been answered.
    checks++;
    if (mq.size() + sq.size() + wq.size() != 0) begin
      errors++;
      $display("FAIL missing_acks got=%0d outstanding required=0",
               mq.size() + sq.size() + wq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
